// File: rtl/serial_add_sequencer_pkg.sv
//==============================================================================
//  Module   : serial_add_pkg
//  Purpose  : Shared state encoding and default width for the bit-serial
//             adder sequencer and its full-adder slice.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_add_pkg;

    // Default operand/sum width of the serial adder.
    localparam int DEFAULT_WIDTH = 64;

    // Sequencer state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage : serial_add_pkg

`default_nettype wire

// File: rtl/serial_add_sequencer_full_adder_bit.sv
//==============================================================================
//  Module   : full_adder_bit
//  Purpose  : Combinational 1-bit full adder (sum and majority carry). Holds
//             no state; the carry flop lives in the sequencer.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum bit and majority carry of the three inputs.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : full_adder_bit

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
//==============================================================================
//  Module   : serial_add_sequencer
//  Purpose  : Bit-serial adder controller. Adds two WIDTH-bit operands plus a
//             carry-in one bit per clock, LSB first, reusing a single carry
//             flop. Results are exposed through a start/busy/done handshake
//             and held until the next accepted start.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Counter value at which the MSB is being added.
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    state_e            r_state;
    logic [WIDTH-1:0]  r_a_sr;
    logic [WIDTH-1:0]  r_b_sr;
    logic [WIDTH-1:0]  r_sum_sr;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_s;
    logic              w_maj;
    logic              w_msb_step;
    logic [WIDTH-1:0]  w_sum_next;

    // The single shared full-adder slice, fed from the operand LSBs.
    full_adder_bit u_full_adder_bit (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_maj)
    );

    // MSB-step detection and the internal sum shift value for this edge.
    always_comb begin
        w_msb_step = (r_cnt == C_LAST_BIT);
        w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
    end

    // Sequencer FSM: operand capture, bit-serial add, result publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    // One full-add per edge; operands drain toward bit 0
                    // while the sum fills in from the top.
                    r_carry  <= w_maj;
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_sum_sr <= w_sum_next;
                    if (w_msb_step) begin
                        // The visible result changes only here, so the
                        // previous answer stays stable throughout RUN.
                        sum      <= w_sum_next;
                        cout     <= w_maj;
                        overflow <= r_carry ^ w_maj;
                        done     <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : serial_add_sequencer

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
//==============================================================================
//  Module   : tb_serial_add_sequencer
//  Purpose  : Self-checking bench for serial_add_sequencer, exercising a
//             64-bit and an 8-bit instance against a bench-side model.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_add_sequencer;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        start64, cin64, busy64, done64, cout64, ovf64;
    logic [63:0] a64, b64, sum64;

    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    exp_t        q64[$];
    exp_t        q8[$];

    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .a(a64), .b(b64), .cin(cin64),
        .busy(busy64), .done(done64), .sum(sum64), .cout(cout64), .overflow(ovf64)
    );

    serial_add_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    // Reference model for the 64-bit instance: unsigned wide add plus sign rule.
    function automatic exp_t model64(input logic [63:0] ta, input logic [63:0] tb, input logic tc);
        exp_t        e;
        logic [64:0] full;
        full   = {1'b0, ta} + {1'b0, tb} + {64'd0, tc};
        e.sum  = full[63:0];
        e.cout = full[64];
        e.ovf  = (ta[63] == tb[63]) && (full[63] != ta[63]);
        return e;
    endfunction

    // Reference model for the 8-bit instance using signed integer range.
    function automatic exp_t model8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        exp_t       e;
        logic [8:0] full;
        int         sa, sb, ss;
        full   = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        sa     = $signed(ta);
        sb     = $signed(tb);
        ss     = sa + sb + int'(tc);
        e.sum  = {56'd0, full[7:0]};
        e.cout = full[8];
        e.ovf  = (ss > 127) || (ss < -128);
        return e;
    endfunction

    // One 64-bit job: drive, score, optionally pulse start at cycles p1/p2.
    task automatic job64(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                         input int p1, input int p2, input string tag);
        exp_t        e;
        logic [63:0] prev;
        int          cyc;
        int          ghost;
        bit          held;
        @(negedge clk);
        prev    = sum64;
        a64     = ta;
        b64     = tb;
        cin64   = tc;
        start64 = 1'b1;
        q64.push_back(model64(ta, tb, tc));
        @(negedge clk);
        start64 = 1'b0;
        a64     = ~ta;
        b64     = ~tb;
        cin64   = ~tc;
        checks++;
        if (busy64 !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept got=%b want=1", tag, busy64);
        end
        cyc  = 0;
        held = 1'b1;
        while (done64 !== 1'b1 && cyc < 256) begin
            if (sum64 !== prev) held = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc == p1 || cyc == p2) begin
                start64 = 1'b1;
                a64     = {$urandom, $urandom};
                b64     = {$urandom, $urandom};
            end else begin
                start64 = 1'b0;
            end
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL %s sum_held_during_run got=changed want=%h", tag, prev);
        end
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL %s done_latency got=%0d want=64", tag, cyc);
        end
        checks++;
        if (q64.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty got=0 want=1", tag);
        end else begin
            e = q64.pop_front();
            if (sum64 !== e.sum || cout64 !== e.cout || ovf64 !== e.ovf) begin
                failures++;
                $display("FAIL %s result got=%h/%b/%b want=%h/%b/%b",
                         tag, sum64, cout64, ovf64, e.sum, e.cout, e.ovf);
            end
        end
        @(negedge clk);
        start64 = 1'b0;
        checks++;
        if (done64 !== 1'b0 || busy64 !== 1'b0) begin
            failures++;
            $display("FAIL %s done_one_cycle got=done%b_busy%b want=done0_busy0", tag, done64, busy64);
        end
        if (p1 >= 0) begin
            ghost = 0;
            repeat (70) begin
                @(negedge clk);
                if (done64 === 1'b1 || busy64 === 1'b1) ghost++;
            end
            checks++;
            if (ghost != 0) begin
                failures++;
                $display("FAIL %s ignored_start_ran got=%0d want=0", tag, ghost);
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0;
        start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy64, done64, sum64, cout64, ovf64} !== 68'd0) begin
            failures++;
            $display("FAIL reset64 got=%b%b_%h_%b%b want=all_zero", busy64, done64, sum64, cout64, ovf64);
        end
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
            failures++;
            $display("FAIL reset8 got=%b%b_%h_%b%b want=all_zero", busy8, done8, sum8, cout8, ovf8);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        job64(64'h5, 64'h3, 1'b0, -1, -1, "basic");
        checks++;
        if (sum64 !== 64'h8 || cout64 !== 1'b0 || ovf64 !== 1'b0) begin
            failures++;
            $display("FAIL basic_const got=%h/%b/%b want=8/0/0", sum64, cout64, ovf64);
        end
    endtask

    task automatic test_carry_overflow();
        job64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, -1, "carry_out");
        checks++;
        if (sum64 !== 64'h0 || cout64 !== 1'b1 || ovf64 !== 1'b0) begin
            failures++;
            $display("FAIL carry_const got=%h/%b/%b want=0/1/0", sum64, cout64, ovf64);
        end
        job64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, -1, "overflow");
        checks++;
        if (sum64 !== 64'h8000_0000_0000_0000 || cout64 !== 1'b0 || ovf64 !== 1'b1) begin
            failures++;
            $display("FAIL overflow_const got=%h/%b/%b want=8000000000000000/0/1", sum64, cout64, ovf64);
        end
    endtask

    task automatic test_ignore_start();
        job64(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 10, 64, "ignore_start");
        checks++;
        if (sum64 !== 64'h1234_5678_9ABC_DF00) begin
            failures++;
            $display("FAIL ignore_const got=%h want=123456789abcdf00", sum64);
        end
    endtask

    task automatic test_reset_mid_run();
        int ghost;
        @(negedge clk);
        a64 = 64'hDEAD_BEEF_0000_1111; b64 = 64'h2222; cin64 = 1'b1; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy64 !== 1'b0 || done64 !== 1'b0 || sum64 !== 64'h0 || cout64 !== 1'b0 || ovf64 !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got=%b%b_%h_%b%b want=all_zero", busy64, done64, sum64, cout64, ovf64);
        end
        ghost = 0;
        repeat (70) begin
            @(negedge clk);
            if (done64 === 1'b1) ghost++;
        end
        checks++;
        if (ghost != 0) begin
            failures++;
            $display("FAIL midrun_no_done got=%0d want=0", ghost);
        end
        job64(64'h1234, 64'h1, 1'b1, -1, -1, "post_reset");
        checks++;
        if (sum64 !== 64'h1236) begin
            failures++;
            $display("FAIL post_reset_const got=%h want=1236", sum64);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ta [3];
        logic [63:0] tb [3];
        logic        tc [3];
        exp_t        e;
        int          accepted, dones, last_done, cyc;
        bit          prev_busy;
        ta[0] = 64'h1111_2222_3333_4444; tb[0] = 64'h0F0F_0F0F_0F0F_0F0F; tc[0] = 1'b1;
        ta[1] = 64'hFFFF_0000_FFFF_0000; tb[1] = 64'h0001_FFFF_0001_FFFF; tc[1] = 1'b0;
        ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'h8000_0000_0000_0001; tc[2] = 1'b1;
        accepted = 0; dones = 0; last_done = -1; cyc = 0;
        @(negedge clk);
        a64 = ta[0]; b64 = tb[0]; cin64 = tc[0]; start64 = 1'b1;
        q64.push_back(model64(ta[0], tb[0], tc[0]));
        prev_busy = busy64;
        while (dones < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (busy64 === 1'b1 && !prev_busy) begin
                accepted++;
                if (accepted < 3) begin
                    a64 = ta[accepted]; b64 = tb[accepted]; cin64 = tc[accepted];
                    q64.push_back(model64(ta[accepted], tb[accepted], tc[accepted]));
                end else begin
                    start64 = 1'b0;
                end
            end
            if (done64 === 1'b1) begin
                dones++;
                checks++;
                if (q64.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_scoreboard_empty got=0 want=1");
                end else begin
                    e = q64.pop_front();
                    if (sum64 !== e.sum || cout64 !== e.cout || ovf64 !== e.ovf) begin
                        failures++;
                        $display("FAIL b2b_result%0d got=%h/%b/%b want=%h/%b/%b",
                                 dones, sum64, cout64, ovf64, e.sum, e.cout, e.ovf);
                    end
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != 66) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d want=66", cyc - last_done);
                    end
                end
                last_done = cyc;
            end
            prev_busy = busy64;
        end
        start64 = 1'b0;
        checks++;
        if (dones != 3) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d want=3", dones);
        end
        q64.delete();
        repeat (70) @(negedge clk);
    endtask

    task automatic test_random8();
        exp_t       e;
        logic [7:0] ta, tb;
        logic       tc;
        int         cyc;
        for (int n = 0; n < 500; n++) begin
            ta = 8'($urandom);
            tb = 8'($urandom);
            tc = 1'($urandom);
            @(negedge clk);
            a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
            q8.push_back(model8(ta, tb, tc));
            @(negedge clk);
            start8 = 1'b0;
            cyc = 0;
            while (done8 !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != 8) begin
                failures++;
                $display("FAIL rand8_latency n=%0d got=%0d want=8", n, cyc);
            end
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL rand8_scoreboard_empty n=%0d got=0 want=1", n);
            end else begin
                e = q8.pop_front();
                if (sum8 !== e.sum[7:0] || cout8 !== e.cout || ovf8 !== e.ovf) begin
                    failures++;
                    $display("FAIL rand8_result n=%0d a=%h b=%h c=%b got=%h/%b/%b want=%h/%b/%b",
                             n, ta, tb, tc, sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_overflow();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_sequencer

`default_nettype wire
